// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the seven-segment digit scanner.
package seg_scan_pkg;

  localparam int  NUM_DIGITS_DEF    = 4;
  localparam int  REFRESH_DIV_DEF   = 100000;
  localparam bit  AN_ACTIVE_LOW_DEF = 1'b1;
  localparam int  MAX_DIGITS        = 8;

  localparam int  PRESC_W_DEF = $clog2(REFRESH_DIV_DEF);
  localparam int  IDX_W_DEF   = $clog2(NUM_DIGITS_DEF);

  typedef logic [3:0] nibble_t;

  function automatic int presc_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot select for digit idx; out-of-range idx yields no active bit.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int idx, input int n);
    return (idx >= 0 && idx < n) ? (MAX_DIGITS'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Value/load control in, scanned digit and anode drive out.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic                    blank_lead;
  logic [3:0]              digit_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    blank;
  logic                    frame_start;

  modport master (
    output value_in, load, blank_lead,
    input  digit_out, an, blank, frame_start
  );

  modport slave (
    input  value_in, load, blank_lead,
    output digit_out, an, blank, frame_start
  );
endinterface

// File: rtl/seg_scan_mux_prescaler.sv
// Free-running divider; tick is high during the last count of each slot.
module refresh_prescaler
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = presc_width(REFRESH_DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode digit scanner; feeds segment_7s.bin_in one nibble per slot.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV   = REFRESH_DIV_DEF,
  parameter bit AN_ACTIVE_LOW = AN_ACTIVE_LOW_DEF
) (
  input logic            clk,
  input logic            rst,
  seg_scan_mux_if.slave  bus
);
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;

  logic                             tick;
  logic [IDX_W-1:0]                 idx, nxt;
  logic [NUM_DIGITS-1:0][3:0]       staged, shadow, disp;
  logic                             upper_zero, blank_nxt;
  logic [NUM_DIGITS-1:0]            oh, an_nxt;

  refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Digit 0 is shown straight from staged so a new frame never mixes values.
  always_comb begin
    nxt  = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    disp = (nxt == '0) ? staged : shadow;

    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(nxt) && disp[j] != 4'd0) upper_zero = 1'b0;

    blank_nxt = bus.blank_lead && (nxt != '0) && upper_zero;
    oh        = NUM_DIGITS'(onehot(int'(nxt), NUM_DIGITS));
    if (blank_nxt)          an_nxt = AN_OFF;
    else if (AN_ACTIVE_LOW) an_nxt = ~oh;
    else                    an_nxt = oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= IDX_W'(NUM_DIGITS - 1);
      staged          <= '0;
      shadow          <= '0;
      bus.digit_out   <= '0;
      bus.an          <= AN_OFF;
      bus.blank       <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      if (bus.load) staged <= bus.value_in;
      bus.frame_start <= 1'b0;
      if (tick) begin
        idx             <= nxt;
        bus.digit_out   <= disp[nxt];
        bus.an          <= an_nxt;
        bus.blank       <= blank_nxt;
        bus.frame_start <= (nxt == '0);
        if (nxt == '0) shadow <= staged;
      end
    end
  end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scanner for a common-anode multi-digit seven-segment display.
- Sits directly upstream of segment_7s. It holds a multi-digit hex value and selects one digit per refresh slot.
- Drives that digit's nibble onto segment_7s.bin_in and asserts the matching anode enable.
- Provides tear-free frame updates and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2); simulation uses 4.
- AN_ACTIVE_LOW, 1, 1 = anode enables active-low; 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- value_in  input  4*NUM_DIGITS  hex value; digit 0 = bits [3:0].
- load  input  1  single-cycle strobe; captures value_in into the staging register.
- blank_lead  input  1  1 = suppress leading zero digits.
- digit_out  output  4  nibble for the active digit; connects to segment_7s.bin_in.
- an  output  NUM_DIGITS  per-digit anode enables.
- blank  output  1  1 = current slot blanked; all anodes inactive.
- frame_start  output  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - prescaler = 0.
  - idx = NUM_DIGITS-1.
  - staged = 0 and shadow = 0.
  - digit_out = 0, blank = 1, frame_start = 0.
  - an = all inactive (all 1s when AN_ACTIVE_LOW = 1).
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted while prescaler == REFRESH_DIV-1.
- Slot advance: on each clk edge with tick asserted:
  - nxt = (idx == NUM_DIGITS-1) ? 0 : idx+1; idx <= nxt.
  - All outputs are registered and update on that same edge from nxt.
  - Outputs hold between ticks.
- Frame boundary (nxt == 0):
  - shadow <= staged.
  - digit_out, blank and an for digit 0 are computed from staged, not the old shadow.
  - frame_start pulses high for exactly 1 cycle.
- Load: load high captures value_in into staged on that edge; shadow is untouched.
  - load coincident with a frame-boundary tick: shadow takes the old staged; the new value displays from the next frame.
  - Back-to-back loads within a frame: the last one wins.
- Digit output: digit_out = nibble nxt of the displayed value.
- Leading-zero blanking: digit k is blanked when all of these hold:
  - blank_lead = 1;
  - k != 0;
  - every nibble j >= k of the displayed value is 0.
  - Digit 0 is never blanked, so value 0 shows "0".
- Anode drive:
  - Not blanked: an = one-hot(nxt), inverted when AN_ACTIVE_LOW = 1.
  - Blanked: an = all inactive and blank = 1. digit_out still carries the nibble (0).
- blank_lead changes take effect at the next tick.
- Latency: the first digit-0 slot begins REFRESH_DIV cycles after reset deassertion. A value loaded at cycle t is visible by the next frame boundary, at most NUM_DIGITS*REFRESH_DIV + REFRESH_DIV cycles later.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); staged content is lost.

Decomposition:
- Package seg_scan_pkg:
  - AN_ACTIVE_LOW default;
  - function onehot(idx, NUM_DIGITS);
  - localparam for prescaler width, $clog2(REFRESH_DIV);
  - localparam for index width, $clog2(NUM_DIGITS).
- Natural sub-module: refresh_prescaler (parameter REFRESH_DIV; ports clk, rst, tick).
- segment_7s stays separate and is instantiated alongside by the top-level.

Test Plan (NUM_DIGITS = 4, REFRESH_DIV = 4, AN_ACTIVE_LOW = 1):
1. Reset and first frame: assert rst for 3 cycles, release, no load.
   - While in reset: an = 4'b1111, blank = 1.
   - After 4 cycles: digit_out = 0, an = 4'b1110, frame_start pulses.
2. Scan order: load value 16'h1A3F, blank_lead = 0, then wait for a frame boundary.
   - Successive slots show digit_out F, 3, A, 1 with an = 1110, 1101, 1011, 0111.
   - Each slot lasts 4 cycles, then the sequence wraps.
3. Tear-free update: load 16'h1234 in the middle of slot 2.
   - Remainder of the frame still shows old digits.
   - The next frame starts with digit_out = 4.
4. Leading-zero blanking: load 16'h0005 with blank_lead = 1.
   - Slot 0: digit_out = 5, an = 1110, blank = 0.
   - Slots 1–3: an = 1111, blank = 1.
   - Load 16'h0000: slot 0 shows 0, slots 1–3 blanked.
5. Simultaneous load and boundary: assert load with 16'hBEEF on the frame-boundary tick edge.
   - That frame shows the previous value.
   - The following frame shows F, E, E, B.
6. Reset mid-operation: assert rst during slot 2 after loading 16'h9876.
   - an goes 1111 and digit_out goes 0 immediately, without waiting for a clock edge.
   - After release: displays 0000, because staged was cleared.
